// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

  // Arbiter FSM states: idle, serving a data access, serving a fetch.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_e;

  // Default number of cycles to wait for mem_ack before giving the port back.
  localparam int unsigned ARB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the memory port arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req until their one-cycle *_ready pulse.
// Ports: fetch side if_*, data side dm_*, memory side mem_*, stall_if/stall_mem, bus_err.
// master = the arbiter's view, slave = the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Watchdog counter for an outstanding memory access; expired when it reaches limit.
// Latency: expired is a compare on the registered count (no extra cycle).
// Backpressure: none; saturates at limit instead of wrapping.
// Ports: Clk, Rst (sync, active-low), clear, enable, limit -> expired.
module arb_timeout_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != limit))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins.
// Latency: zero-wait access gives ready 2 cycles after the request; +1 per wait state.
// Backpressure: stall_if/stall_mem hold requesters; watchdog aborts after TIMEOUT cycles.
// Ports: Clk, Rst (sync, active-low), bus (mem_port_arbiter_if.master).
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  mem_port_arbiter_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic              bus_err_q;

  logic busy;
  logic expired;

  assign busy = (state_q != ARB_IDLE);

  // Held at zero while idle, so every BUSY entry starts from a cleared count.
  arb_timeout_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (!busy),
    .enable  (busy),
    .limit   (CNT_W'(TIMEOUT - 1)),
    .expired (expired)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // A requester whose ready is high this cycle is dropping its request.
          if (bus.dm_req && !dm_ready_q) begin
            state_q     <= ARB_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
          end else if (bus.if_req && !if_ready_q) begin
            state_q    <= ARB_BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
          end
        end
        ARB_BUSY_D, ARB_BUSY_I: begin
          // An ack in the expiry cycle still counts as a successful access.
          if (bus.mem_ack || expired) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            bus_err_q <= !bus.mem_ack;
            if (state_q == ARB_BUSY_D) begin
              dm_ready_q <= 1'b1;
              if (!bus.mem_ack)
                dm_rdata_q <= '0;
              else if (!mem_we_q)
                dm_rdata_q <= bus.mem_rdata;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req && !if_ready_q;
  assign bus.stall_mem = bus.dm_req && !dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan episodes, a
// mid-access reset, then randomized episodes checked against a transaction model.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int TO = ARB_TIMEOUT_DEF;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_dm_rdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // -1 = memory never acks; TO-1 = ack lands in the watchdog's last cycle.
  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -1;
    if (r == 1) return TO - 1;
    return int'($urandom_range(0, 4));
  endfunction

  // Requests raised together in cycle 0 with the arbiter idle. Expected timing:
  // an access with w wait states completes with ready in cycle w+2 (timeout:
  // TO+1); a fetch behind a data access starts counting from the data ready cycle.
  task automatic run_episode(input string name, input bit do_f, input bit do_d,
                             input logic [31:0] f_addr, input int f_wait, input logic [31:0] f_data,
                             input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
                             input int d_wait, input logic [31:0] d_data);
    logic [31:0] t_addr [2];
    logic        t_we   [2];
    logic [31:0] t_wd   [2];
    bit          t_is_d [2];
    int          t_wait [2];
    logic [31:0] t_rd   [2];
    int n_tx, d_lat, f_lat, exp_d_rdy, exp_f_rdy, exp_err, last_evt;
    int f_rdy_cyc, d_rdy_cyc, f_rdy_cnt, d_rdy_cnt, err_cnt, stall_f, stall_d;
    int tx, len, seen_tx;
    logic [31:0] f_rd_obs, d_rd_obs, s_addr, s_wd, exp_v;
    logic f_err_obs, d_err_obs, s_we;
    bit in_tx, unstable, ack, done;

    n_tx = 0;
    if (do_d) begin
      t_addr[n_tx] = d_addr; t_we[n_tx] = d_we; t_wd[n_tx] = d_wdata;
      t_is_d[n_tx] = 1'b1; t_wait[n_tx] = d_wait; t_rd[n_tx] = d_data; n_tx++;
    end
    if (do_f) begin
      t_addr[n_tx] = f_addr; t_we[n_tx] = 1'b0; t_wd[n_tx] = '0;
      t_is_d[n_tx] = 1'b0; t_wait[n_tx] = f_wait; t_rd[n_tx] = f_data; n_tx++;
    end
    d_lat     = (d_wait < 0) ? TO + 1 : d_wait + 2;
    f_lat     = (f_wait < 0) ? TO + 1 : f_wait + 2;
    exp_d_rdy = do_d ? d_lat : -1;
    exp_f_rdy = do_f ? ((do_d ? d_lat : 0) + f_lat) : -1;
    exp_err   = ((do_d && d_wait < 0) ? 1 : 0) + ((do_f && f_wait < 0) ? 1 : 0);
    last_evt  = (exp_d_rdy > exp_f_rdy) ? exp_d_rdy : exp_f_rdy;

    f_rdy_cyc = -1; d_rdy_cyc = -1; f_rdy_cnt = 0; d_rdy_cnt = 0; err_cnt = 0;
    stall_f = 0; stall_d = 0; tx = -1; len = 0; seen_tx = 0;
    f_rd_obs = '0; d_rd_obs = '0; f_err_obs = 1'b0; d_err_obs = 1'b0;
    s_addr = '0; s_wd = '0; s_we = 1'b0; in_tx = 1'b0; unstable = 1'b0; done = 1'b0;

    for (int c = 0; c < 120; c++) begin
      @(posedge Clk); #1;
      if (bus.if_ready) begin
        f_rdy_cnt++; if (f_rdy_cyc < 0) f_rdy_cyc = c;
        f_rd_obs = bus.if_rdata; f_err_obs = bus.bus_err;
      end
      if (bus.dm_ready) begin
        d_rdy_cnt++; if (d_rdy_cyc < 0) d_rdy_cyc = c;
        d_rd_obs = bus.dm_rdata; d_err_obs = bus.bus_err;
      end
      if (bus.bus_err) err_cnt++;

      ack = 1'b0;
      if (bus.mem_req) begin
        if (!in_tx) begin
          in_tx = 1'b1; tx++; len = 0; unstable = 1'b0; seen_tx++;
          s_addr = bus.mem_addr; s_we = bus.mem_we; s_wd = bus.mem_wdata;
          if (tx < n_tx) begin
            check_eq({name, " mem_addr"}, bus.mem_addr, t_addr[tx]);
            check_eq({name, " mem_we"}, 32'(bus.mem_we), 32'(t_we[tx]));
            if (t_is_d[tx] && t_we[tx])
              check_eq({name, " mem_wdata"}, bus.mem_wdata, t_wd[tx]);
          end
        end else if (bus.mem_addr !== s_addr || bus.mem_we !== s_we || bus.mem_wdata !== s_wd) begin
          unstable = 1'b1;
        end
        len++;
        if (tx < n_tx && t_wait[tx] >= 0 && (len - 1) == t_wait[tx]) ack = 1'b1;
      end else begin
        if (in_tx) begin
          in_tx = 1'b0;
          if (tx < n_tx)
            check_eq({name, " mem_req cycles"}, len, (t_wait[tx] < 0) ? TO : t_wait[tx] + 1);
          check_eq({name, " mem_* stable"}, 32'(unstable), 32'd0);
        end
        ack = ($urandom_range(0, 3) == 0);   // stray ack while the port is idle
      end
      bus.mem_ack   = ack;
      bus.mem_rdata = (ack && in_tx && tx < n_tx) ? t_rd[tx] : $urandom;

      // Requests stay up through the ready cycle and drop on the next one.
      bus.if_req   = do_f && !(f_rdy_cyc >= 0 && f_rdy_cyc < c);
      bus.if_addr  = bus.if_req ? f_addr : $urandom;
      bus.dm_req   = do_d && !(d_rdy_cyc >= 0 && d_rdy_cyc < c);
      bus.dm_we    = bus.dm_req ? d_we : 1'($urandom_range(0, 1));
      bus.dm_addr  = bus.dm_req ? d_addr : $urandom;
      bus.dm_wdata = bus.dm_req ? d_wdata : $urandom;
      #1;
      stall_f += int'(bus.stall_if);
      stall_d += int'(bus.stall_mem);
      if (c > last_evt && !bus.mem_req && !in_tx) begin
        done = 1'b1;
        break;
      end
    end

    check_eq({name, " finished in budget"}, 32'(done), 32'd1);
    check_eq({name, " transactions"}, seen_tx, n_tx);
    check_eq({name, " bus_err pulses"}, err_cnt, exp_err);
    if (do_f) begin
      exp_v = (f_wait < 0) ? 32'd0 : f_data;
      check_eq({name, " if_ready cycle"}, f_rdy_cyc, exp_f_rdy);
      check_eq({name, " if_ready pulses"}, f_rdy_cnt, 1);
      check_eq({name, " if_rdata"}, f_rd_obs, exp_v);
      check_eq({name, " bus_err with if_ready"}, 32'(f_err_obs), (f_wait < 0) ? 32'd1 : 32'd0);
      check_eq({name, " stall_if cycles"}, stall_f, exp_f_rdy);
      m_if_rdata = exp_v;
    end else begin
      check_eq({name, " no if_ready"}, f_rdy_cnt, 0);
      check_eq({name, " if_rdata held"}, bus.if_rdata, m_if_rdata);
    end
    if (do_d) begin
      exp_v = (d_wait < 0) ? 32'd0 : (d_we ? m_dm_rdata : d_data);
      check_eq({name, " dm_ready cycle"}, d_rdy_cyc, exp_d_rdy);
      check_eq({name, " dm_ready pulses"}, d_rdy_cnt, 1);
      check_eq({name, " dm_rdata"}, d_rd_obs, exp_v);
      check_eq({name, " bus_err with dm_ready"}, 32'(d_err_obs), (d_wait < 0) ? 32'd1 : 32'd0);
      check_eq({name, " stall_mem cycles"}, stall_d, exp_d_rdy);
      m_dm_rdata = exp_v;
    end else begin
      check_eq({name, " no dm_ready"}, d_rdy_cnt, 0);
      check_eq({name, " dm_rdata held"}, bus.dm_rdata, m_dm_rdata);
    end
  endtask

  // Reset during a fetch, stray ack right after, then the held fetch is regranted.
  task automatic run_reset_test();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0100;
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      if (bus.mem_req) break;
    end
    check_eq("rst: fetch granted", 32'(bus.mem_req), 32'd1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    check_eq("rst: mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst: mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst: if_ready", 32'(bus.if_ready), 32'd0);
    check_eq("rst: if_rdata", bus.if_rdata, 32'd0);
    check_eq("rst: dm_rdata", bus.dm_rdata, 32'd0);
    check_eq("rst: bus_err", 32'(bus.bus_err), 32'd0);
    Rst = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    @(posedge Clk); #1;
    check_eq("rst: stray ack no if_ready", 32'(bus.if_ready), 32'd0);
    check_eq("rst: stray ack if_rdata", bus.if_rdata, 32'd0);
    check_eq("rst: regrant mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("rst: regrant mem_addr", bus.mem_addr, 32'h0040_0100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1357_9BDF;
    @(posedge Clk); #1;
    bus.mem_ack = 1'b0;
    check_eq("rst: if_ready after regrant", 32'(bus.if_ready), 32'd1);
    check_eq("rst: if_rdata after regrant", bus.if_rdata, 32'h1357_9BDF);
    check_eq("rst: bus_err after regrant", 32'(bus.bus_err), 32'd0);
    @(posedge Clk); #1;
    check_eq("rst: no regrant on ready", 32'(bus.mem_req), 32'd0);
    bus.if_req = 1'b0;
    m_if_rdata = 32'h1357_9BDF;
    m_dm_rdata = '0;
  endtask

  initial begin
    int sel, gap;
    bit df, dd;
    drive_idle();
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("reset mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("reset mem_addr", bus.mem_addr, 32'd0);
    check_eq("reset mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("reset if_rdata", bus.if_rdata, 32'd0);
    check_eq("reset dm_rdata", bus.dm_rdata, 32'd0);
    check_eq("reset if_ready", 32'(bus.if_ready), 32'd0);
    check_eq("reset dm_ready", 32'(bus.dm_ready), 32'd0);
    check_eq("reset bus_err", 32'(bus.bus_err), 32'd0);
    Rst = 1'b1;

    run_episode("lone_fetch", 1'b1, 1'b0, 32'h0040_0000, 0, 32'h2008_0005,
                1'b0, 32'd0, 32'd0, 0, 32'd0);
    run_episode("fetch_and_load", 1'b1, 1'b1, 32'h0040_0004, 0, 32'h1234_5678,
                1'b0, 32'h1001_0000, 32'd0, 0, 32'hCAFE_0001);
    run_episode("store_3ws", 1'b0, 1'b1, 32'd0, 0, 32'd0,
                1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 3, 32'h5555_AAAA);
    run_episode("timeout", 1'b0, 1'b1, 32'd0, 0, 32'd0,
                1'b0, 32'h1001_000C, 32'd0, -1, 32'd0);
    run_episode("ack_at_limit", 1'b1, 1'b0, 32'h0040_0008, TO - 1, 32'h0BAD_F00D,
                1'b0, 32'd0, 32'd0, 0, 32'd0);
    run_reset_test();

    for (int e = 0; e < 40; e++) begin
      sel = int'($urandom_range(0, 2));
      df  = (sel != 1);
      dd  = (sel != 0);
      run_episode("random", df, dd, $urandom, pick_wait(), $urandom,
                  1'($urandom_range(0, 1)), $urandom, $urandom, pick_wait(), $urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge Clk); #1;
        bus.mem_ack = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
